thresholding_cfg_loader: RTL and testbench
==========================================

Name: thresholding_cfg_loader

Overview:
- Initiator for the threshold configuration port (cfg_en/cfg_we/cfg_a/cfg_d/cfg_rack/cfg_q) of the binary-search thresholding core.
- Write mode: takes a flat AXI-Stream of threshold values and issues one config write per value, mapped to the core's set/channel-fold/PE/threshold address layout.
- Read mode: issues readbacks in the same order and returns the values on an output stream, using credit-based flow control so readback data is never lost.
- Sits between a DMA/host stream and the thresholding core.

Parameters:
- K, 8, threshold precision in bits.
- N, 3, thresholds per channel (N >= 1).
- C, 4, number of channels.
- PE, 2, processing elements (C % PE == 0).
- SETS, 1, number of threshold sets.
- RB_DEPTH, 8, readback FIFO depth (>= 2), which equals the read credit count.
- Derived localparams: CF = C/PE; AW = $clog2(SETS)+$clog2(CF)+$clog2(PE)+$clog2(N); TOTAL = SETS*C*N.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start_wr  in  1  pulse: begin write sequence
- start_rd  in  1  pulse: begin readback sequence
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when sequence completes
- err  out  1  sticky: cfg_rack received with no read outstanding
- s_tvalid  in  1  threshold input valid
- s_tready  out  1  threshold input ready
- s_tdata  in  K  threshold value
- m_tvalid  out  1  readback output valid
- m_tready  in  1  readback output ready
- m_tdata  out  K  readback value
- cfg_en  out  1  config access enable
- cfg_we  out  1  1 = write, 0 = readback
- cfg_a  out  AW  config address
- cfg_d  out  K  write data
- cfg_rack  in  1  readback acknowledge (arbitrary fixed latency)
- cfg_q  in  K  readback data, valid with cfg_rack

Behaviour:
- FSM states: IDLE, WRITE, READ, DRAIN. All outputs are registered.
- Reset values: busy=0, done=0, err=0, s_tready=0, m_tvalid=0, cfg_en=0, cfg_we=0, cfg_a=0, cfg_d=0. Credits reset to RB_DEPTH; FIFO is emptied; all counters reset to 0.
- IDLE:
  - start_wr -> WRITE. start_rd -> READ. If both are asserted together, WRITE wins and start_rd is dropped.
  - Starts are ignored when not in IDLE.
  - busy=1 in every state other than IDLE.
- Enumeration order, fastest to slowest: t (0..N-1), pe (0..PE-1), cf (0..CF-1), set (0..SETS-1).
  - Stream index i = ((set*CF + cf)*PE + pe)*N + t, which means channel c = cf*PE + pe.
- Address: cfg_a = {set, cf, pe, t}, with field widths $clog2(SETS), $clog2(CF), $clog2(PE), $clog2(N). Zero-width fields are omitted. Padded threshold slots are never accessed.
- WRITE:
  - s_tready=1 while in WRITE.
  - Each accepted beat produces, on the next cycle: cfg_en=1, cfg_we=1, cfg_a = address of the current counters, cfg_d = s_tdata. Counters then advance.
  - Throughput is 1 write/cycle. With no beat, cfg_en=0 on the next cycle.
  - After beat TOTAL-1 is accepted: s_tready drops in the same registered update; the last write is issued; then done=1 for one cycle, and the FSM returns to IDLE with busy=0.
- READ:
  - A read is issued (next cycle cfg_en=1, cfg_we=0, cfg_d=0) when credits > 0 and issued < TOTAL.
  - Credits decrement on issue and increment on an m_tvalid&&m_tready pop. Issue and pop in the same cycle leave credits unchanged.
  - cfg_rack pushes cfg_q into the FIFO. The credit scheme guarantees the FIFO never overflows; assert this in simulation.
  - After issued == TOTAL -> DRAIN.
- DRAIN:
  - Wait until received == TOTAL and the FIFO is empty, then pulse done and go to IDLE.
  - Under m_tready=0 the block stalls, issuing nothing.
- m_tdata/m_tvalid are driven from the FIFO head (first-word fall-through, registered). Output order equals issue order.
- cfg_rack while outstanding == 0: err <= 1 (sticky until rst) and the data is discarded.
- rst mid-sequence: immediate abort. The next cycle shows cfg_en=0 and the FIFO is flushed. Late cfg_rack beats arriving after reset set err.
- Counter widths: $clog2(TOTAL+1) for issued/received; $clog2(RB_DEPTH+1) for credits.

Test Plan:
- Write order (defaults K=8, N=3, C=4, PE=2): start_wr, stream 12 values 0x10..0x1B back-to-back -> 12 consecutive cfg writes at cfg_a = 0,1,2,4,5,6,8,9,10,12,13,14 with cfg_d 0x10..0x1B; done pulses once; busy low afterwards.
- Gapped input: s_tvalid toggling 1/0 -> cfg_en toggles accordingly; addresses and data are unchanged from the back-to-back case; no address is skipped or duplicated.
- Readback with latency 3 (responder model returns mem[cfg_a]) and m_tready=1 -> m_tdata yields 0x10..0x1B in order; no more than RB_DEPTH reads are outstanding at any time.
- Backpressure: m_tready=0 for 20 cycles mid-read -> exactly RB_DEPTH=8 reads issued then stall; on release all 12 values arrive in order with none lost; done pulses.
- start_wr and start_rd in the same cycle -> write sequence only; start_rd asserted again during busy is ignored.
- rst asserted after 5 writes -> cfg_en=0 the next cycle, busy=0; a fresh start_wr restarts at cfg_a=0. A spurious cfg_rack in IDLE -> err=1, m_tvalid stays 0.

Source files
------------

// File: rtl/thresholding_cfg_loader.sv
// Config-port initiator for the binary-search thresholding core: streams thresholds
// into the core (write mode) or reads them back onto an output stream (read mode).
module thresholding_cfg_loader #(
  parameter int unsigned K        = 8,
  parameter int unsigned N        = 3,
  parameter int unsigned C        = 4,
  parameter int unsigned PE       = 2,
  parameter int unsigned SETS     = 1,
  parameter int unsigned RB_DEPTH = 8,
  localparam int unsigned CF      = C / PE,
  localparam int unsigned AW      = $clog2(SETS) + $clog2(CF) + $clog2(PE) + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          start_wr,
  input  logic          start_rd,
  output logic          busy,
  output logic          done,
  output logic          err,

  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [K-1:0]  s_tdata,

  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [K-1:0]  m_tdata,

  output logic          cfg_en,
  output logic          cfg_we,
  output logic [AW-1:0] cfg_a,
  output logic [K-1:0]  cfg_d,
  input  logic          cfg_rack,
  input  logic [K-1:0]  cfg_q
);

  localparam int unsigned WS    = $clog2(SETS);
  localparam int unsigned WCF   = $clog2(CF);
  localparam int unsigned WPE   = $clog2(PE);
  localparam int unsigned WT    = $clog2(N);
  localparam int unsigned SW    = (WS  > 0) ? WS  : 1;
  localparam int unsigned CFW   = (WCF > 0) ? WCF : 1;
  localparam int unsigned PEW   = (WPE > 0) ? WPE : 1;
  localparam int unsigned TW    = (WT  > 0) ? WT  : 1;
  localparam int unsigned TOTAL = SETS * C * N;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned RW    = $clog2(RB_DEPTH + 1);
  localparam int unsigned PW    = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state_q;
  state_t state_nxt;

  // Enumeration counters, fastest (t) to slowest (set)
  logic [TW-1:0]  t_q,   t_nxt;
  logic [PEW-1:0] pe_q,  pe_nxt;
  logic [CFW-1:0] cf_q,  cf_nxt;
  logic [SW-1:0]  set_q, set_nxt;

  logic [CW-1:0]  issued_q,  issued_nxt;
  logic [CW-1:0]  rcvd_q,    rcvd_nxt;
  logic [RW-1:0]  credits_q, credits_nxt;
  logic [RW-1:0]  out_q,     out_nxt;

  // Readback FIFO; the head is mirrored into the m_tdata/m_tvalid registers
  logic [K-1:0]   mem [RB_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_nxt;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_nxt;
  logic [RW-1:0]  cnt_q, cnt_after_pop, cnt_nxt;
  logic [K-1:0]   head_nxt;
  logic           head_valid_nxt;

  logic           accept;
  logic           rd_issue;
  logic           step;
  logic           pop;
  logic           push;
  logic           orphan;
  logic           starting;
  logic           busy_nxt;
  logic           done_nxt;
  logic           s_tready_nxt;
  logic [AW-1:0]  cur_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RB_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Address layout {set, cf, pe, t}; zero-width fields shift by zero and stay 0
  always_comb begin
    cur_addr = AW'((((((32'(set_q) << WCF) | 32'(cf_q)) << WPE) | 32'(pe_q)) << WT)
                   | 32'(t_q));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_nxt = WRITE;
        end else if (start_rd) begin
          state_nxt = READ;
        end
      end
      WRITE: begin
        if (issued_q == CW'(TOTAL)) begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        if (issued_q == CW'(TOTAL)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((rcvd_q == CW'(TOTAL)) && (cnt_q == '0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    accept   = (state_q == WRITE) && s_tready && s_tvalid;
    rd_issue = (state_q == READ) && (credits_q != '0) && (issued_q < CW'(TOTAL));
    step     = accept || rd_issue;
    pop      = m_tvalid && m_tready;
    push     = cfg_rack && (out_q != '0);
    orphan   = cfg_rack && (out_q == '0);
    starting = (state_q == IDLE) && (state_nxt != IDLE);

    t_nxt   = t_q;
    pe_nxt  = pe_q;
    cf_nxt  = cf_q;
    set_nxt = set_q;
    if (starting) begin
      t_nxt   = '0;
      pe_nxt  = '0;
      cf_nxt  = '0;
      set_nxt = '0;
    end else if (step) begin
      if (t_q == TW'(N - 1)) begin
        t_nxt = '0;
        if (pe_q == PEW'(PE - 1)) begin
          pe_nxt = '0;
          if (cf_q == CFW'(CF - 1)) begin
            cf_nxt  = '0;
            set_nxt = (set_q == SW'(SETS - 1)) ? '0 : set_q + SW'(1);
          end else begin
            cf_nxt = cf_q + CFW'(1);
          end
        end else begin
          pe_nxt = pe_q + PEW'(1);
        end
      end else begin
        t_nxt = t_q + TW'(1);
      end
    end

    issued_nxt  = starting ? '0 : issued_q + CW'(step);
    rcvd_nxt    = starting ? '0 : rcvd_q + CW'(push);
    credits_nxt = credits_q - RW'(rd_issue) + RW'(pop);
    out_nxt     = out_q + RW'(rd_issue) - RW'(push);

    busy_nxt     = (state_nxt != IDLE);
    done_nxt     = (state_q != IDLE) && (state_nxt == IDLE);
    s_tready_nxt = (state_nxt == WRITE) && (issued_nxt < CW'(TOTAL));

    cnt_after_pop  = cnt_q - RW'(pop);
    rd_ptr_nxt     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_nxt     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_nxt        = cnt_after_pop + RW'(push);
    head_valid_nxt = (cnt_after_pop != '0) || push;
    head_nxt       = (cnt_after_pop == '0) ? cfg_q : mem[rd_ptr_nxt];
  end

  // Registered outputs, counters and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      s_tready  <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      cfg_en    <= 1'b0;
      cfg_we    <= 1'b0;
      cfg_a     <= '0;
      cfg_d     <= '0;
      t_q       <= '0;
      pe_q      <= '0;
      cf_q      <= '0;
      set_q     <= '0;
      issued_q  <= '0;
      rcvd_q    <= '0;
      credits_q <= RW'(RB_DEPTH);
      out_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err | orphan;
      s_tready  <= s_tready_nxt;
      m_tvalid  <= head_valid_nxt;
      m_tdata   <= head_nxt;
      cfg_en    <= step;
      if (step) begin
        cfg_we <= accept;
        cfg_a  <= cur_addr;
        cfg_d  <= accept ? s_tdata : '0;
      end
      t_q       <= t_nxt;
      pe_q      <= pe_nxt;
      cf_q      <= cf_nxt;
      set_q     <= set_nxt;
      issued_q  <= issued_nxt;
      rcvd_q    <= rcvd_nxt;
      credits_q <= credits_nxt;
      out_q     <= out_nxt;
      wr_ptr_q  <= wr_ptr_nxt;
      rd_ptr_q  <= rd_ptr_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  // FIFO storage needs no reset; validity lives in cnt_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= cfg_q;
    end
  end

  // Credits bound outstanding reads plus stored entries, so a push never meets a full FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (cnt_q == RW'(RB_DEPTH))));
    end
  end

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Directed bench for thresholding_cfg_loader with a fixed-latency config responder.
module tb_thresholding_cfg_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_wr, start_rd;
  logic       busy, done, err;
  logic       s_tvalid, s_tready;
  logic [7:0] s_tdata;
  logic       m_tvalid, m_tready;
  logic [7:0] m_tdata;
  logic       cfg_en, cfg_we;
  logic [3:0] cfg_a;
  logic [7:0] cfg_d;
  logic       cfg_rack;
  logic [7:0] cfg_q;

  always #5 clk = ~clk;

  thresholding_cfg_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start_wr (start_wr),
    .start_rd (start_rd),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .cfg_en   (cfg_en),
    .cfg_we   (cfg_we),
    .cfg_a    (cfg_a),
    .cfg_d    (cfg_d),
    .cfg_rack (cfg_rack),
    .cfg_q    (cfg_q)
  );

  // Core model: config memory plus a 3-stage readback pipeline
  logic [7:0] mem [16] = '{default: 8'h00};
  logic [2:0] p_v = 3'b000;
  logic [3:0] p_a [3] = '{default: 4'd0};
  logic       spur = 1'b0;
  int         n_rd = 0;
  int         tb_out = 0;
  int         max_out = 0;
  logic [7:0] rd_q [$];

  assign cfg_rack = p_v[2] | spur;
  assign cfg_q    = mem[p_a[2]];

  always @(posedge clk) begin
    p_v    <= {p_v[1:0], cfg_en && !cfg_we};
    p_a[0] <= cfg_a;
    p_a[1] <= p_a[0];
    p_a[2] <= p_a[1];
    if (cfg_en && cfg_we) mem[cfg_a] <= cfg_d;
    if (cfg_en && !cfg_we) n_rd <= n_rd + 1;
    tb_out <= tb_out + ((cfg_en && !cfg_we) ? 1 : 0) - (p_v[2] ? 1 : 0);
    if (tb_out > max_out) max_out <= tb_out;
    if (m_tvalid && m_tready) rd_q.push_back(m_tdata);
  end

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_en;
    logic [3:0] exp_a;
    logic [7:0] exp_d;
    logic       exp_rdy;
  } vec_t;

  vec_t       vt [32];
  int         nv;
  logic [3:0] addr_tab [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
                                4'd8, 4'd9, 4'd10, 4'd12, 4'd13, 4'd14};
  int         checks = 0;
  int         errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic build_table(input bit gapped);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      vt[nv] = '{1'b1, 8'(32'h10 + k), 1'b1, addr_tab[k], 8'(32'h10 + k), (k < 11)};
      nv++;
      if (gapped) begin
        vt[nv] = '{1'b0, 8'hEE, 1'b0, 4'd0, 8'h00, (k < 11)};
        nv++;
      end
    end
    if (!gapped) begin
      vt[nv] = '{1'b0, 8'hEE, 1'b0, 4'd0, 8'h00, 1'b0};
      nv++;
    end
  endtask

  task automatic start_write(input bit both);
    start_wr = 1'b1;
    start_rd = both;
    tick();
    start_wr = 1'b0;
    start_rd = 1'b0;
    chk("wr_start_busy", 32'(busy), 32'd1);
    chk("wr_start_ready", 32'(s_tready), 32'd1);
  endtask

  // Final table entry is the idle cycle on which done appears
  task automatic run_vectors(input int rd_poke);
    for (int i = 0; i < nv; i++) begin
      s_tvalid = vt[i].valid;
      s_tdata  = vt[i].data;
      start_rd = (i == rd_poke);
      tick();
      chk($sformatf("vec%0d_en", i), 32'(cfg_en), 32'(vt[i].exp_en));
      chk($sformatf("vec%0d_rdy", i), 32'(s_tready), 32'(vt[i].exp_rdy));
      if (vt[i].exp_en) begin
        chk($sformatf("vec%0d_we", i), 32'(cfg_we), 32'd1);
        chk($sformatf("vec%0d_a", i), 32'(cfg_a), 32'(vt[i].exp_a));
        chk($sformatf("vec%0d_d", i), 32'(cfg_d), 32'(vt[i].exp_d));
      end
    end
    s_tvalid = 1'b0;
    start_rd = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_busy_after", 32'(busy), 32'd0);
    tick();
    chk("wr_done_pulse", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input int max_cycles);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < max_cycles) begin
      tick();
      if (done) seen = 1'b1;
      n++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic check_readback(input int base);
    chk("rb_count", 32'(rd_q.size() - base), 32'd12);
    for (int k = 0; k < 12; k++) begin
      if (base + k < rd_q.size())
        chk($sformatf("rb%0d", k), 32'(rd_q[base + k]), 32'h10 + 32'(k));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int base_q;
    int base_rd;
    rst      = 1'b1;
    start_wr = 1'b0;
    start_rd = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    m_tready = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(s_tready), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_cfg_en", 32'(cfg_en), 32'd0);
    chk("rst_cfg_we", 32'(cfg_we), 32'd0);
    chk("rst_cfg_a", 32'(cfg_a), 32'd0);
    chk("rst_cfg_d", 32'(cfg_d), 32'd0);
    rst = 1'b0;
    tick();

    // Both starts together, plus start_rd while busy: write only
    base_rd = n_rd;
    start_write(1'b1);
    build_table(1'b0);
    run_vectors(5);
    repeat (10) tick();
    chk("no_read_issued", 32'(n_rd - base_rd), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_mvalid", 32'(m_tvalid), 32'd0);

    // Gapped input stream
    start_write(1'b0);
    build_table(1'b1);
    run_vectors(-1);

    // Readback, free-running sink
    base_q  = rd_q.size();
    base_rd = n_rd;
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    chk("rd_busy", 32'(busy), 32'd1);
    wait_done(300);
    check_readback(base_q);
    chk("rd_issued", 32'(n_rd - base_rd), 32'd12);
    chk("max_outstanding_ok", 32'(max_out <= 8), 32'd1);

    // Readback under backpressure
    tick();
    m_tready = 1'b0;
    base_q   = rd_q.size();
    base_rd  = n_rd;
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    repeat (20) tick();
    chk("bp_issued", 32'(n_rd - base_rd), 32'd8);
    chk("bp_mvalid", 32'(m_tvalid), 32'd1);
    chk("bp_head", 32'(m_tdata), 32'h10);
    chk("bp_busy", 32'(busy), 32'd1);
    m_tready = 1'b1;
    wait_done(300);
    check_readback(base_q);
    chk("bp_total_issued", 32'(n_rd - base_rd), 32'd12);

    // Spurious readback acknowledge in IDLE
    tick();
    chk("err_clear", 32'(err), 32'd0);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_err", 32'(err), 32'd1);
    chk("spur_mvalid", 32'(m_tvalid), 32'd0);
    tick();
    chk("spur_err_sticky", 32'(err), 32'd1);
    chk("spur_mvalid_hold", 32'(m_tvalid), 32'd0);

    // Reset after five writes, then restart from address 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_rst", 32'(err), 32'd0);
    start_write(1'b0);
    for (int k = 0; k < 5; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(32'h40 + k);
      tick();
      chk($sformatf("abort_wr%0d_a", k), 32'(cfg_a), 32'(addr_tab[k]));
    end
    rst = 1'b1;
    tick();
    chk("abort_cfg_en", 32'(cfg_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(s_tready), 32'd0);
    rst      = 1'b0;
    s_tvalid = 1'b0;
    tick();
    start_write(1'b0);
    build_table(1'b0);
    run_vectors(-1);

    // Reset during readback: late acknowledges flag err and are dropped
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rdabort_cfg_en", 32'(cfg_en), 32'd0);
    chk("rdabort_mvalid", 32'(m_tvalid), 32'd0);
    chk("rdabort_err0", 32'(err), 32'd0);
    repeat (6) tick();
    chk("late_rack_err", 32'(err), 32'd1);
    chk("late_rack_mvalid", 32'(m_tvalid), 32'd0);
    chk("late_rack_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
